// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: scan FSM states, key-count flag and hex legend.
// The KEYPAD_HEX_MAP_EN macro selects the hex legend in keypad_scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StDrive,
        StSample,
        StDwell
    } scan_state_e;

    typedef enum logic [1:0] {
        KeysNone,
        KeysOne,
        KeysMany
    } key_count_e;

    // Board legend, indexed by r*4 + c with row 0 at the top.
    localparam logic [3:0] HEX_LEGEND [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // "No key" is carried as a cleared valid bit beside the code.
    localparam logic CAND_NONE = 1'b0;

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and event bundle; the scanner uses the master modport, game logic the slave.
interface keypad_if #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
);
    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;
    logic              key_release;
    logic              multi_press;

    modport master (
        input  row,
        output col, key_code, key_valid, key_held, key_release, multi_press
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_held, key_release, multi_press
    );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: tracks the previous candidate and a stability count, and turns
// stable frames into press/release events and the held level.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned CODE_W         = 4,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eval_i,
    input  logic [CODE_W-1:0] code_i,
    input  key_count_e        count_i,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_held_o,
    output logic              key_release_o,
    output logic              multi_press_o
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic              prev_valid_q, prev_valid_d;
    logic [CODE_W-1:0] prev_code_q, prev_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic [CODE_W-1:0] code_q, code_d;
    logic              held_q, held_d;
    logic              valid_q, valid_d;
    logic              release_q, release_d;
    logic              multi_q, multi_d;
    logic              cand_valid, same;

    assign cand_valid = (count_i == KeysOne);
    assign same = (cand_valid == prev_valid_q) && (!cand_valid || code_i == prev_code_q);

    always_comb begin
        prev_valid_d = prev_valid_q;
        prev_code_d  = prev_code_q;
        cnt_d        = cnt_q;
        cnt_next     = '0;
        code_d       = code_q;
        held_d       = held_q;
        valid_d      = 1'b0;
        release_d    = 1'b0;
        multi_d      = 1'b0;
        if (eval_i) begin
            if (count_i == KeysMany) begin
                // Ghosted frame: only the stability count is disturbed.
                multi_d = 1'b1;
                cnt_d   = '0;
            end else begin
                if (same) begin
                    cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_next     = CNT_W'(1);
                    prev_valid_d = cand_valid;
                    prev_code_d  = code_i;
                end
                cnt_d = cnt_next;
                if (cnt_next == CNT_MAX) begin
                    if (cand_valid && (!held_q || code_i != code_q)) begin
                        code_d  = code_i;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end else if (!cand_valid && held_q) begin
                        release_d = 1'b1;
                        held_d    = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid_q <= CAND_NONE;
            prev_code_q  <= '0;
            cnt_q        <= '0;
            code_q       <= '0;
            held_q       <= 1'b0;
            valid_q      <= 1'b0;
            release_q    <= 1'b0;
            multi_q      <= 1'b0;
        end else begin
            prev_valid_q <= prev_valid_d;
            prev_code_q  <= prev_code_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            held_q       <= held_d;
            valid_q      <= valid_d;
            release_q    <= release_d;
            multi_q      <= multi_d;
        end
    end

    assign key_code_o    = code_q;
    assign key_valid_o   = valid_q;
    assign key_held_o    = held_q;
    assign key_release_o = release_q;
    assign multi_press_o = multi_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive FSM, row synchronizer and frame image, feeding the debouncer.
// Define KEYPAD_HEX_MAP_EN (4x4 only) to report codes through the board hex legend.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned COL_TICKS      = 100000,
    parameter int unsigned SETTLE_TICKS   = 8,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic      clk,
    input logic      rst,
    keypad_if.master kp
);
    localparam int unsigned KEYS   = ROWS * COLS;
    localparam int unsigned CODE_W = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int unsigned TICK_W = $clog2(COL_TICKS);
    localparam int unsigned COL_W  = $clog2(COLS);

`ifdef KEYPAD_HEX_MAP_EN
    if (ROWS != 4 || COLS != 4) begin : g_bad_geometry
        $error("KEYPAD_HEX_MAP_EN needs a 4x4 keypad");
    end
`endif

    scan_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [COL_W-1:0]  col_idx_q, col_idx_d;
    logic [COLS-1:0]   col_q, col_d;
    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [KEYS-1:0]   frame_q, frame_d;
    logic              last_tick, eval;
    int unsigned       n_pressed;
    logic [CODE_W-1:0] lin_code, cand_code;
    key_count_e        key_count;

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        frame_d   = frame_q;
        eval      = 1'b0;
        last_tick = (tick_q == TICK_W'(COL_TICKS - 1));
        tick_d    = last_tick ? '0 : tick_q + 1'b1;
        unique case (state_q)
            StDrive: if (tick_q == TICK_W'(SETTLE_TICKS - 1)) state_d = StSample;
            StSample: begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (col_idx_q == COL_W'(c)) begin
                        for (int unsigned r = 0; r < ROWS; r++) begin
                            frame_d[r*COLS + c] = ~row_sync_q[r];
                        end
                    end
                end
                state_d = StDwell;
            end
            StDwell: begin
                if (last_tick) begin
                    state_d = StDrive;
                    if (col_idx_q == COL_W'(COLS - 1)) begin
                        eval      = 1'b1;
                        col_idx_d = '0;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StDrive;
        endcase
        // Track the next index so col changes on the same edge the column starts.
        col_d = ~(COLS'(1) << col_idx_d);
    end

    always_comb begin
        n_pressed = 0;
        lin_code  = '0;
        for (int unsigned i = 0; i < KEYS; i++) begin
            if (frame_q[i]) begin
                n_pressed = n_pressed + 1;
                lin_code  = CODE_W'(i);
            end
        end
        if (n_pressed == 0)      key_count = KeysNone;
        else if (n_pressed == 1) key_count = KeysOne;
        else                     key_count = KeysMany;
    end

`ifdef KEYPAD_HEX_MAP_EN
    assign cand_code = CODE_W'(HEX_LEGEND[lin_code]);
`else
    assign cand_code = lin_code;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StDrive;
            tick_q     <= '0;
            col_idx_q  <= '0;
            col_q      <= '1;
            row_meta_q <= '1;
            row_sync_q <= '1;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            row_meta_q <= kp.row;
            row_sync_q <= row_meta_q;
            frame_q    <= frame_d;
        end
    end

    assign kp.col = col_q;

    keypad_debounce #(
        .CODE_W        (CODE_W),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .eval_i       (eval),
        .code_i       (cand_code),
        .count_i      (key_count),
        .key_code_o   (kp.key_code),
        .key_valid_o  (kp.key_valid),
        .key_held_o   (kp.key_held),
        .key_release_o(kp.key_release),
        .multi_press_o(kp.multi_press)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives the rows from the column outputs,
// stimulus is applied on frame boundaries and expected values are hand-computed constants.
module tb_keypad_scanner;
    localparam int unsigned ROWS           = 4;
    localparam int unsigned COLS           = 4;
    localparam int unsigned COL_TICKS      = 16;
    localparam int unsigned SETTLE_TICKS   = 4;
    localparam int unsigned DEBOUNCE_SCANS = 2;
    localparam int unsigned FRAME          = COLS * COL_TICKS;
    // Key index r*4+c: index 2 is row 0 col 2, index 1 is row 0 col 1.
`ifdef KEYPAD_HEX_MAP_EN
    localparam int unsigned EXP_K2 = 3;
    localparam int unsigned EXP_K1 = 2;
`else
    localparam int unsigned EXP_K2 = 2;
    localparam int unsigned EXP_K1 = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;

    keypad_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

    keypad_scanner #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .COL_TICKS     (COL_TICKS),
        .SETTLE_TICKS  (SETTLE_TICKS),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            kp.row[r] = ~|(pressed[r*COLS +: COLS] & ~kp.col);
        end
    end

    int unsigned cyc = 0, n_valid = 0, n_rel = 0, n_multi = 0;
    int unsigned last_valid_cyc = 0, last_rel_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (kp.key_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (kp.key_release) begin
            n_rel        <= n_rel + 1;
            last_rel_cyc <= cyc;
        end
        if (kp.multi_press) n_multi <= n_multi + 1;
    end

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " col"}, 32'(kp.col), 32'hF);
        check({tag, " key_code"}, 32'(kp.key_code), 0);
        check({tag, " key_valid"}, 32'(kp.key_valid), 0);
        check({tag, " key_held"}, 32'(kp.key_held), 0);
        check({tag, " key_release"}, 32'(kp.key_release), 0);
        check({tag, " multi_press"}, 32'(kp.multi_press), 0);
    endtask

    int unsigned v0, r0, m0, t0, lat;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Column stepping; edge 64 after reset release is a frame boundary.
        tick(1);  check("col edge1", 32'(kp.col), 32'hE);
        tick(14); check("col edge15", 32'(kp.col), 32'hE);
        tick(1);  check("col edge16", 32'(kp.col), 32'hD);
        tick(16); check("col edge32", 32'(kp.col), 32'hB);
        tick(16); check("col edge48", 32'(kp.col), 32'h7);
        tick(16); check("col wrap", 32'(kp.col), 32'hE);
        v0 = n_valid; r0 = n_rel; m0 = n_multi;
        tick(3 * FRAME);
        check("idle valid", n_valid - v0, 0);
        check("idle release", n_rel - r0, 0);
        check("idle multi", n_multi - m0, 0);

        // Press row 0 col 2.
        v0 = n_valid; r0 = n_rel; t0 = cyc;
        pressed[2] = 1'b1;
        tick(4 * FRAME);
        lat = last_valid_cyc - t0;
        check("press valid count", n_valid - v0, 1);
        check("press latency", 32'((lat >= 2*FRAME - COL_TICKS) && (lat <= 3*FRAME)), 1);
        check("press code", 32'(kp.key_code), EXP_K2);
        check("press held", 32'(kp.key_held), 1);
        check("press no release", n_rel - r0, 0);

        // Release it.
        v0 = n_valid; r0 = n_rel; t0 = cyc;
        pressed = '0;
        tick(4 * FRAME);
        lat = last_rel_cyc - t0;
        check("release count", n_rel - r0, 1);
        check("release latency", 32'((lat >= 2*FRAME - COL_TICKS) && (lat <= 3*FRAME)), 1);
        check("release held", 32'(kp.key_held), 0);
        check("release code kept", 32'(kp.key_code), EXP_K2);
        check("release no valid", n_valid - v0, 0);

        // One-frame bounce on row 1.
        v0 = n_valid; r0 = n_rel;
        pressed[4] = 1'b1;
        tick(FRAME);
        pressed = '0;
        tick(3 * FRAME);
        check("bounce valid", n_valid - v0, 0);
        check("bounce release", n_rel - r0, 0);
        check("bounce held", 32'(kp.key_held), 0);

        // Hold row 0 col 1, then add row 1 col 1 in the same column.
        v0 = n_valid;
        pressed[1] = 1'b1;
        tick(4 * FRAME);
        check("hold valid count", n_valid - v0, 1);
        check("hold code", 32'(kp.key_code), EXP_K1);
        v0 = n_valid; r0 = n_rel; m0 = n_multi;
        pressed[5] = 1'b1;
        tick(3 * FRAME + 2);
        check("multi count", n_multi - m0, 3);
        check("multi no valid", n_valid - v0, 0);
        check("multi no release", n_rel - r0, 0);
        check("multi held", 32'(kp.key_held), 1);
        check("multi code", 32'(kp.key_code), EXP_K1);
        pressed[5] = 1'b0;
        v0 = n_valid;
        tick(3 * FRAME - 2);
        check("ghost cleared no valid", n_valid - v0, 0);
        check("ghost cleared held", 32'(kp.key_held), 1);

        // Reset mid-column with the key still held.
        tick(20);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        v0 = n_valid; r0 = n_rel;
        tick(3);
        @(negedge clk);
        rst = 1'b0;
        tick(3 * FRAME);
        check("post reset valid", n_valid - v0, 1);
        check("post reset code", 32'(kp.key_code), EXP_K1);
        check("post reset held", 32'(kp.key_held), 1);
        check("post reset no release", n_rel - r0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
